mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- FSM sequences each instruction through IF/ID/EX/MEM/WB and drives the datapath enables (PC, IR, register file, memory) per state.
- Supports memory wait states through a ready handshake and counts retired instructions.
- Sits in the multi-cycle CPU top, beside the datapath, NPC, ALU and a shared instruction/data memory port.

Parameters:
- ALUOP_W, 4, ALUOp width; codes below use the low 4 bits, upper bits are 0.
- MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as always 1.
- CNT_W, 32, width of the instret counter.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- Op  in  6  opcode from IR.
- Funct  in  6  funct from IR.
- Zero  in  1  ALU zero flag, valid in EX.
- mem_ready  in  1  memory completes the current request this cycle.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR load enable.
- RegWrite  out  1  register file write enable.
- MemRead  out  1  memory read request (fetch or lw).
- MemWrite  out  1  memory write request (sw).
- IorD  out  1  memory address source: 0 = PC, 1 = ALU result register.
- EXTOp  out  1  1 = sign-extend immediate.
- ALUOp  out  ALUOP_W  ALU operation.
- NPCOp  out  2  00 PLUS4, 01 BRANCH, 10 JUMP, 11 JR.
- ALUSrc  out  1  1 = ALU B from immediate.
- AREGSel  out  1  1 = ALU A from shamt.
- GPRSel  out  2  00 rd, 01 rt, 10 $31.
- WDSel  out  2  00 ALU, 01 MEM, 10 PC.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- state_o  out  3  current state, for debug.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- One clock domain; rstn is synchronous and active-low.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4. Codes 5–7 go to IF on the next edge.
- Supported instructions: add, addu, sub, subu, and, or, nor, slt, sltu, sll, srl, sllv, srlv, jr, jalr, addi, andi, ori, slti, lui, lw, sw, beq, bne, j, jal.
- Reset: while rstn=0 on an edge, state<=IF and instret<=0. Reset mid-instruction abandons it with no write.
- All outputs are combinational from state, Op, Funct, Zero and mem_ready. While rstn=0, every enable and request (PCWrite, IRWrite, RegWrite, MemRead, MemWrite, illegal) is forced to 0; all other outputs read 0.
- IF:
  - MemRead=1, IorD=0.
  - When mem_ready=1: IRWrite=1, PCWrite=1 with NPCOp=PLUS4, go to ID. Otherwise hold in IF with MemRead held high.
- ID: decode only. Combinational enables are asserted in ID and take effect at the ID→next edge.
  - j: PCWrite, NPCOp=JUMP, go to IF.
  - jal: as j, plus RegWrite, GPRSel=10, WDSel=10 (PC already holds PC+4).
  - jr: PCWrite, NPCOp=JR, go to IF.
  - jalr: as jr, plus RegWrite, GPRSel=10, WDSel=10.
  - Undecodable: illegal=1, no write, go to IF (treated as a NOP).
  - All others go to EX.
- EX: ALUOp, ALUSrc, AREGSel and EXTOp are driven as in the single-cycle decoder.
  - ALUOp codes: NOP 0, ADD 1, SUB 2, AND 3, OR 4, SLT 5, SLTU 6, SLL 7, SRL 8, LUI 9, NOR A.
  - beq/bne: PCWrite = Zero for beq, ~Zero for bne; NPCOp=BRANCH; go to IF.
  - lw/sw: ADD with the sign-extended immediate, go to MEM.
  - All others go to WB.
- MEM: IorD=1; MemRead=lw, MemWrite=sw. The request is held until mem_ready=1.
  - On ready, sw goes to IF; lw goes to WB.
  - A sw write commits only in the ready cycle.
- WB: RegWrite=1. GPRSel=01 for I-type, 00 for R-type. WDSel=01 for lw, 00 otherwise. Go to IF.
- ALU-related outputs are held through MEM and WB so the datapath registers stay consistent.
- instret increments by 1 on every transition into IF from ID, EX, MEM or WB, including illegal instructions. It does not increment on IF→IF stalls. It wraps modulo 2^CNT_W.
- CPI: j/jr 2, branch 3, R/I-type 4, sw 4, lw 5, plus one cycle per mem_ready=0 cycle.

Decomposition:
- Package mc_ctrl_pkg holds the state enum, ALUOp, NPCOp, GPRSel and WDSel codes, and the opcode/funct constants. It is shared with the datapath and ALU.
- One sub-module, mc_ctrl_dec: a purely combinational decoder of Op/Funct to instruction class and ALU fields. The FSM and counter live in mc_ctrl.

Test Plan:
- Reset: rstn=0 for 2 cycles mid-EX of an add → state_o=0, instret=0, RegWrite=0; first post-reset cycle shows MemRead=1.
- add $3,$1,$2 with mem_ready=1 → states 0,1,2,4,0. ALUOp=1 in EX. RegWrite=1, GPRSel=00 only in WB. instret +1 after 4 cycles.
- lw with mem_ready=0 for 2 cycles in MEM → MEM lasts 3 cycles, MemRead and IorD held at 1, WB has WDSel=01. Total 7 cycles.
- beq with Zero=1, then bne with Zero=1 → PCWrite=1/NPCOp=01 in EX for beq; PCWrite=0 for bne. Each 3 cycles.
- jal, then Op=6'h3F → jal: ID has PCWrite=1, RegWrite=1, GPRSel=10, WDSel=10. Op=6'h3F: illegal pulses 1 cycle, no write enables, instret still increments.
- CNT_W=4, retire 17 instructions → instret=1, showing wrap.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS controller.
// Holds the FSM state encoding, the ALUOp / NPCOp / GPRSel / WDSel codes,
// the opcode and funct constants, and the decoded-instruction record that
// the decoder hands to the FSM. The datapath and ALU import the same codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    // ALU operation codes (low 4 bits of ALUOp)
    localparam logic [3:0] ALU_NOP  = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_AND  = 4'h3;
    localparam logic [3:0] ALU_OR   = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_SLTU = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_LUI  = 4'h9;
    localparam logic [3:0] ALU_NOR  = 4'hA;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    localparam logic [1:0] GPR_RD = 2'b00;
    localparam logic [1:0] GPR_RT = 2'b01;
    localparam logic [1:0] GPR_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Instruction class: decides the path through the FSM
    typedef enum logic [2:0] {
        C_ILLEGAL = 3'd0,
        C_RALU    = 3'd1,
        C_IALU    = 3'd2,
        C_LOAD    = 3'd3,
        C_STORE   = 3'd4,
        C_BRANCH  = 3'd5,
        C_JUMP    = 3'd6,
        C_JREG    = 3'd7
    } iclass_e;

    typedef struct packed {
        iclass_e    cls;
        logic       link;     // jal/jalr: also write PC+4 to $31
        logic       bne;      // branch on not-equal
        logic [3:0] aluop;
        logic       alusrc;
        logic       aregsel;
        logic       extop;
    } dec_t;

    function automatic dec_t mk_dec(iclass_e cls, logic [3:0] aluop,
                                    logic alusrc, logic aregsel, logic extop);
        dec_t d;
        d.cls     = cls;
        d.link    = 1'b0;
        d.bne     = 1'b0;
        d.aluop   = aluop;
        d.alusrc  = alusrc;
        d.aregsel = aregsel;
        d.extop   = extop;
        return d;
    endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: purely combinational instruction decoder.
// Maps Op/Funct to an instruction class plus the ALU control fields used
// while the FSM is in EX/MEM/WB.
//   i_op    [5:0]  opcode from IR
//   i_funct [5:0]  funct from IR (ignored unless i_op is R-type)
//   o_dec          decoded record (class, link, bne, ALU fields)
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output dec_t       o_dec
);

    always_comb begin
        o_dec = mk_dec(C_ILLEGAL, ALU_NOP, 1'b0, 1'b0, 1'b0);
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD, FN_ADDU: o_dec = mk_dec(C_RALU, ALU_ADD,  1'b0, 1'b0, 1'b0);
                    FN_SUB, FN_SUBU: o_dec = mk_dec(C_RALU, ALU_SUB,  1'b0, 1'b0, 1'b0);
                    FN_AND:          o_dec = mk_dec(C_RALU, ALU_AND,  1'b0, 1'b0, 1'b0);
                    FN_OR:           o_dec = mk_dec(C_RALU, ALU_OR,   1'b0, 1'b0, 1'b0);
                    FN_NOR:          o_dec = mk_dec(C_RALU, ALU_NOR,  1'b0, 1'b0, 1'b0);
                    FN_SLT:          o_dec = mk_dec(C_RALU, ALU_SLT,  1'b0, 1'b0, 1'b0);
                    FN_SLTU:         o_dec = mk_dec(C_RALU, ALU_SLTU, 1'b0, 1'b0, 1'b0);
                    // Constant shifts take the amount from shamt; variable ones from rs
                    FN_SLL:          o_dec = mk_dec(C_RALU, ALU_SLL,  1'b0, 1'b1, 1'b0);
                    FN_SRL:          o_dec = mk_dec(C_RALU, ALU_SRL,  1'b0, 1'b1, 1'b0);
                    FN_SLLV:         o_dec = mk_dec(C_RALU, ALU_SLL,  1'b0, 1'b0, 1'b0);
                    FN_SRLV:         o_dec = mk_dec(C_RALU, ALU_SRL,  1'b0, 1'b0, 1'b0);
                    FN_JR:           o_dec = mk_dec(C_JREG, ALU_NOP,  1'b0, 1'b0, 1'b0);
                    FN_JALR: begin
                        o_dec      = mk_dec(C_JREG, ALU_NOP, 1'b0, 1'b0, 1'b0);
                        o_dec.link = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: o_dec = mk_dec(C_IALU,   ALU_ADD,  1'b1, 1'b0, 1'b1);
            OP_SLTI: o_dec = mk_dec(C_IALU,   ALU_SLT,  1'b1, 1'b0, 1'b1);
            // Logical immediates and lui are zero-extended
            OP_ANDI: o_dec = mk_dec(C_IALU,   ALU_AND,  1'b1, 1'b0, 1'b0);
            OP_ORI:  o_dec = mk_dec(C_IALU,   ALU_OR,   1'b1, 1'b0, 1'b0);
            OP_LUI:  o_dec = mk_dec(C_IALU,   ALU_LUI,  1'b1, 1'b0, 1'b0);
            OP_LW:   o_dec = mk_dec(C_LOAD,   ALU_ADD,  1'b1, 1'b0, 1'b1);
            OP_SW:   o_dec = mk_dec(C_STORE,  ALU_ADD,  1'b1, 1'b0, 1'b1);
            OP_BEQ:  o_dec = mk_dec(C_BRANCH, ALU_SUB,  1'b0, 1'b0, 1'b1);
            OP_BNE: begin
                o_dec     = mk_dec(C_BRANCH, ALU_SUB, 1'b0, 1'b0, 1'b1);
                o_dec.bne = 1'b1;
            end
            OP_J:    o_dec = mk_dec(C_JUMP,   ALU_NOP,  1'b0, 1'b0, 1'b0);
            OP_JAL: begin
                o_dec      = mk_dec(C_JUMP, ALU_NOP, 1'b0, 1'b0, 1'b0);
                o_dec.link = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit.
// Steps each instruction through IF/ID/EX/MEM/WB, drives the datapath
// enables per state, stalls on memory via mem_ready, and counts retired
// instructions.
//   clk, rstn                 clock (rising edge), synchronous active-low reset
//   Op, Funct                 instruction fields from IR
//   Zero                      ALU zero flag (used in EX for branches)
//   mem_ready                 memory completes current request this cycle
//   PCWrite/IRWrite/RegWrite  load/write enables
//   MemRead/MemWrite/IorD     memory request and address source
//   EXTOp/ALUOp/ALUSrc/AREGSel ALU control (valid in EX, held in MEM/WB)
//   NPCOp/GPRSel/WDSel        next-PC, write-register and write-data selects
//   illegal                   one-cycle pulse on undecodable instruction
//   state_o                   current FSM state (debug)
//   instret                   retired-instruction count
module mc_ctrl #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_WAIT_EN = 1,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         NPCOp,
    output logic               ALUSrc,
    output logic               AREGSel,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               illegal,
    output logic [2:0]         state_o,
    output logic [CNT_W-1:0]   instret
);
    import mc_ctrl_pkg::*;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_instret;
    state_e           w_state_next;
    dec_t             w_dec;
    logic             w_ready;
    logic             w_retire;
    logic [3:0]       w_aluop;

    mc_ctrl_dec u_dec (
        .i_op    (Op),
        .i_funct (Funct),
        .o_dec   (w_dec)
    );

    assign w_ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    // Retire on any return to IF from a working state; IF->IF stalls and
    // recovery from the unused codes 5..7 do not count.
    assign w_retire = ((r_state == S_ID) || (r_state == S_EX) ||
                       (r_state == S_MEM) || (r_state == S_WB)) &&
                      (w_state_next == S_IF);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_IF;
            r_instret <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = S_IF;
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IorD         = 1'b0;
        EXTOp        = 1'b0;
        w_aluop      = ALU_NOP;
        NPCOp        = NPC_PLUS4;
        ALUSrc       = 1'b0;
        AREGSel      = 1'b0;
        GPRSel       = GPR_RD;
        WDSel        = WD_ALU;
        illegal      = 1'b0;

        // ALU controls stay up through MEM and WB so the ALU result
        // register is not disturbed by a changing operation.
        if ((r_state == S_EX) || (r_state == S_MEM) || (r_state == S_WB)) begin
            w_aluop = w_dec.aluop;
            ALUSrc  = w_dec.alusrc;
            AREGSel = w_dec.aregsel;
            EXTOp   = w_dec.extop;
        end

        case (r_state)
            S_IF: begin
                MemRead = 1'b1;
                if (w_ready) begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    w_state_next = S_ID;
                end else begin
                    w_state_next = S_IF;
                end
            end
            S_ID: begin
                case (w_dec.cls)
                    C_JUMP, C_JREG: begin
                        PCWrite = 1'b1;
                        NPCOp   = (w_dec.cls == C_JUMP) ? NPC_JUMP : NPC_JR;
                        // PC already holds PC+4 from IF, so it is the link value
                        if (w_dec.link) begin
                            RegWrite = 1'b1;
                            GPRSel   = GPR_RA;
                            WDSel    = WD_PC;
                        end
                    end
                    C_ILLEGAL: illegal = 1'b1;
                    default:   w_state_next = S_EX;
                endcase
            end
            S_EX: begin
                if (w_dec.cls == C_BRANCH) begin
                    PCWrite = w_dec.bne ? ~Zero : Zero;
                    NPCOp   = NPC_BRANCH;
                end else if ((w_dec.cls == C_LOAD) || (w_dec.cls == C_STORE)) begin
                    w_state_next = S_MEM;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = (w_dec.cls == C_LOAD);
                MemWrite = (w_dec.cls == C_STORE);
                if (!w_ready) begin
                    w_state_next = S_MEM;
                end else if (w_dec.cls == C_LOAD) begin
                    w_state_next = S_WB;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                GPRSel   = (w_dec.cls == C_RALU) ? GPR_RD : GPR_RT;
                WDSel    = (w_dec.cls == C_LOAD) ? WD_MEM : WD_ALU;
            end
            default: ;
        endcase

        if (!rstn) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IorD     = 1'b0;
            EXTOp    = 1'b0;
            w_aluop  = ALU_NOP;
            NPCOp    = NPC_PLUS4;
            ALUSrc   = 1'b0;
            AREGSel  = 1'b0;
            GPRSel   = GPR_RD;
            WDSel    = WD_ALU;
            illegal  = 1'b0;
        end
    end

    // Zero-extend the 4-bit code to the configured ALUOp width
    genvar gi;
    generate
        for (gi = 0; gi < ALUOP_W; gi++) begin : g_aluop
            if (gi < 4) begin : g_code
                assign ALUOp[gi] = w_aluop[gi];
            end else begin : g_pad
                assign ALUOp[gi] = 1'b0;
            end
        end
    endgenerate

    assign state_o = rstn ? r_state   : 3'd0;
    assign instret = rstn ? r_instret : '0;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed plus randomized check of mc_ctrl against a
// per-instruction reference model. Two instances share the stimulus: one
// with the default 32-bit counter and one with a 4-bit counter for wrap.
module tb_mc_ctrl;

    logic clk;
    logic rstn, Zero, mem_ready;
    logic [5:0] Op, Funct;

    logic [1:0] pcw, irw, rw, mr, mw, iord, ext, src, areg, ill;
    logic [3:0] alu [2];
    logic [1:0] npc [2];
    logic [1:0] gpr [2];
    logic [1:0] wd  [2];
    logic [2:0] st  [2];
    logic [31:0] ir32;
    logic [3:0]  ir4;

    int vectors     = 0;
    int miscompares = 0;
    int retired     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(pcw[0]), .IRWrite(irw[0]), .RegWrite(rw[0]), .MemRead(mr[0]), .MemWrite(mw[0]),
        .IorD(iord[0]), .EXTOp(ext[0]), .ALUOp(alu[0]), .NPCOp(npc[0]), .ALUSrc(src[0]),
        .AREGSel(areg[0]), .GPRSel(gpr[0]), .WDSel(wd[0]), .illegal(ill[0]),
        .state_o(st[0]), .instret(ir32)
    );

    mc_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(pcw[1]), .IRWrite(irw[1]), .RegWrite(rw[1]), .MemRead(mr[1]), .MemWrite(mw[1]),
        .IorD(iord[1]), .EXTOp(ext[1]), .ALUOp(alu[1]), .NPCOp(npc[1]), .ALUSrc(src[1]),
        .AREGSel(areg[1]), .GPRSel(gpr[1]), .WDSel(wd[1]), .illegal(ill[1]),
        .state_o(st[1]), .instret(ir4)
    );

    typedef struct packed {
        logic [2:0] st;
        logic pcw, irw, rw, mr, mw, iord, ext;
        logic [3:0] alu;
        logic [1:0] npc;
        logic src, areg;
        logic [1:0] gpr, wd;
        logic ill;
    } obs_t;

    localparam logic [3:0] K_R = 4'd0, K_I = 4'd1, K_LW = 4'd2, K_SW = 4'd3,
                           K_BEQ = 4'd4, K_BNE = 4'd5, K_J = 4'd6, K_JAL = 4'd7,
                           K_JR = 4'd8, K_JALR = 4'd9, K_ILL = 4'd10;

    typedef struct packed {
        logic [5:0] op, funct;
        logic [3:0] kind, alu;
        logic src, areg, ext;
    } ent_t;

    localparam int N_ENT = 28;
    localparam int E_ADD = 0, E_LW = 20, E_SW = 21, E_BEQ = 22, E_BNE = 23,
                   E_J = 24, E_JAL = 25, E_ILL = 26, E_JALR = 14;

    // Instruction table: op, funct, behaviour kind, ALUOp, ALUSrc, AREGSel, EXTOp
    function automatic ent_t get_ent(int i);
        ent_t e;
        case (i)
            0:  e = '{6'h00, 6'h20, K_R,    4'h1, 1'b0, 1'b0, 1'b0}; // add
            1:  e = '{6'h00, 6'h21, K_R,    4'h1, 1'b0, 1'b0, 1'b0}; // addu
            2:  e = '{6'h00, 6'h22, K_R,    4'h2, 1'b0, 1'b0, 1'b0}; // sub
            3:  e = '{6'h00, 6'h23, K_R,    4'h2, 1'b0, 1'b0, 1'b0}; // subu
            4:  e = '{6'h00, 6'h24, K_R,    4'h3, 1'b0, 1'b0, 1'b0}; // and
            5:  e = '{6'h00, 6'h25, K_R,    4'h4, 1'b0, 1'b0, 1'b0}; // or
            6:  e = '{6'h00, 6'h27, K_R,    4'hA, 1'b0, 1'b0, 1'b0}; // nor
            7:  e = '{6'h00, 6'h2A, K_R,    4'h5, 1'b0, 1'b0, 1'b0}; // slt
            8:  e = '{6'h00, 6'h2B, K_R,    4'h6, 1'b0, 1'b0, 1'b0}; // sltu
            9:  e = '{6'h00, 6'h00, K_R,    4'h7, 1'b0, 1'b1, 1'b0}; // sll
            10: e = '{6'h00, 6'h02, K_R,    4'h8, 1'b0, 1'b1, 1'b0}; // srl
            11: e = '{6'h00, 6'h04, K_R,    4'h7, 1'b0, 1'b0, 1'b0}; // sllv
            12: e = '{6'h00, 6'h06, K_R,    4'h8, 1'b0, 1'b0, 1'b0}; // srlv
            13: e = '{6'h00, 6'h08, K_JR,   4'h0, 1'b0, 1'b0, 1'b0}; // jr
            14: e = '{6'h00, 6'h09, K_JALR, 4'h0, 1'b0, 1'b0, 1'b0}; // jalr
            15: e = '{6'h08, 6'h00, K_I,    4'h1, 1'b1, 1'b0, 1'b1}; // addi
            16: e = '{6'h0C, 6'h00, K_I,    4'h3, 1'b1, 1'b0, 1'b0}; // andi
            17: e = '{6'h0D, 6'h00, K_I,    4'h4, 1'b1, 1'b0, 1'b0}; // ori
            18: e = '{6'h0A, 6'h00, K_I,    4'h5, 1'b1, 1'b0, 1'b1}; // slti
            19: e = '{6'h0F, 6'h00, K_I,    4'h9, 1'b1, 1'b0, 1'b0}; // lui
            20: e = '{6'h23, 6'h00, K_LW,   4'h1, 1'b1, 1'b0, 1'b1}; // lw
            21: e = '{6'h2B, 6'h00, K_SW,   4'h1, 1'b1, 1'b0, 1'b1}; // sw
            22: e = '{6'h04, 6'h00, K_BEQ,  4'h2, 1'b0, 1'b0, 1'b1}; // beq
            23: e = '{6'h05, 6'h00, K_BNE,  4'h2, 1'b0, 1'b0, 1'b1}; // bne
            24: e = '{6'h02, 6'h00, K_J,    4'h0, 1'b0, 1'b0, 1'b0}; // j
            25: e = '{6'h03, 6'h00, K_JAL,  4'h0, 1'b0, 1'b0, 1'b0}; // jal
            26: e = '{6'h3F, 6'h00, K_ILL,  4'h0, 1'b0, 1'b0, 1'b0}; // bad opcode
            default: e = '{6'h00, 6'h01, K_ILL, 4'h0, 1'b0, 1'b0, 1'b0}; // bad funct
        endcase
        return e;
    endfunction

    // Expected outputs for instruction e in phase ph (0 IF .. 4 WB)
    function automatic obs_t model(ent_t e, int ph, bit rdy, bit z);
        obs_t o = '0;
        o.st = 3'(ph);
        if (ph >= 2) begin
            o.alu = e.alu; o.src = e.src; o.areg = e.areg; o.ext = e.ext;
        end
        case (ph)
            0: begin
                o.mr = 1'b1;
                if (rdy) begin o.irw = 1'b1; o.pcw = 1'b1; end
            end
            1: begin
                if (e.kind == K_J || e.kind == K_JAL) begin o.pcw = 1'b1; o.npc = 2'b10; end
                if (e.kind == K_JR || e.kind == K_JALR) begin o.pcw = 1'b1; o.npc = 2'b11; end
                if (e.kind == K_JAL || e.kind == K_JALR) begin
                    o.rw = 1'b1; o.gpr = 2'b10; o.wd = 2'b10;
                end
                if (e.kind == K_ILL) o.ill = 1'b1;
            end
            2: begin
                if (e.kind == K_BEQ) begin o.pcw = z;  o.npc = 2'b01; end
                if (e.kind == K_BNE) begin o.pcw = !z; o.npc = 2'b01; end
            end
            3: begin
                o.iord = 1'b1;
                o.mr = (e.kind == K_LW);
                o.mw = (e.kind == K_SW);
            end
            4: begin
                o.rw  = 1'b1;
                o.gpr = (e.kind == K_R)  ? 2'b00 : 2'b01;
                o.wd  = (e.kind == K_LW) ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
        return o;
    endfunction

    function automatic obs_t get_obs(int k);
        obs_t o;
        o.st = st[k]; o.pcw = pcw[k]; o.irw = irw[k]; o.rw = rw[k]; o.mr = mr[k];
        o.mw = mw[k]; o.iord = iord[k]; o.ext = ext[k]; o.alu = alu[k]; o.npc = npc[k];
        o.src = src[k]; o.areg = areg[k]; o.gpr = gpr[k]; o.wd = wd[k]; o.ill = ill[k];
        return o;
    endfunction

    task automatic cmp_obs(obs_t ex, string tag);
        for (int k = 0; k < 2; k++) begin
            obs_t ob = get_obs(k);
            vectors++;
            assert (ob === ex) else begin
                miscompares++;
                $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, ob, ex);
            end
        end
    endtask

    task automatic cmp_cnt(string tag);
        vectors++;
        assert (ir32 === 32'(retired)) else begin
            miscompares++;
            $error("FAIL %s instret32 observed=%0d expected=%0d", tag, ir32, retired);
        end
        vectors++;
        assert (ir4 === 4'(retired)) else begin
            miscompares++;
            $error("FAIL %s instret4 observed=%0d expected=%0d", tag, ir4, 4'(retired));
        end
    endtask

    // Hold rstn low across n clock edges, checking that everything reads 0
    task automatic do_reset(int n);
        rstn = 1'b0;
        retired = 0;
        #1;
        cmp_obs('0, "reset_enter");
        cmp_cnt("reset_enter");
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cmp_obs('0, "reset_hold");
            cmp_cnt("reset_hold");
        end
        rstn = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            assert (st[k] === 3'd0) else begin
                miscompares++;
                $error("FAIL reset_release dut%0d state observed=%0d expected=0", k, st[k]);
            end
        end
        cmp_cnt("reset_release");
        $display("reset: %0d edges, state/instret cleared", n);
    endtask

    // Run one instruction; zmode 0/1 forces Zero, 2 randomises it per cycle.
    // stop_at >= 0 abandons the instruction after that many checked cycles.
    task automatic run_instr(int idx, int if_st, int mem_st, int zmode, int stop_at);
        ent_t e = get_ent(idx);
        int   ph_q[$];
        bit   rdy_q[$];
        int   n;
        Op    = e.op;
        Funct = (e.op == 6'h00) ? e.funct : 6'($urandom);
        repeat (if_st) begin ph_q.push_back(0); rdy_q.push_back(1'b0); end
        ph_q.push_back(0); rdy_q.push_back(1'b1);
        ph_q.push_back(1); rdy_q.push_back(1'($urandom));
        if (e.kind inside {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE}) begin
            ph_q.push_back(2); rdy_q.push_back(1'($urandom));
        end
        if (e.kind == K_LW || e.kind == K_SW) begin
            repeat (mem_st) begin ph_q.push_back(3); rdy_q.push_back(1'b0); end
            ph_q.push_back(3); rdy_q.push_back(1'b1);
        end
        if (e.kind inside {K_R, K_I, K_LW}) begin
            ph_q.push_back(4); rdy_q.push_back(1'($urandom));
        end
        n = (stop_at < 0) ? ph_q.size() : stop_at;
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            mem_ready = rdy_q[p];
            Zero      = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            cmp_obs(model(e, ph_q[p], rdy_q[p], Zero),
                    $sformatf("instr%0d_op%h_fn%h_cyc%0d", idx, Op, Funct, p));
        end
        if (stop_at < 0) begin
            @(posedge clk); #1;
            retired++;
            cmp_cnt($sformatf("instret_after_instr%0d", idx));
            $display("instr idx=%0d op=%h funct=%h cycles=%0d retired=%0d",
                     idx, Op, Funct, n, retired);
        end else begin
            $display("instr idx=%0d op=%h funct=%h abandoned after %0d cycles",
                     idx, Op, Funct, n);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Op = 6'h00; Funct = 6'h00; Zero = 1'b0; mem_ready = 1'b0; rstn = 1'b0;
        do_reset(2);

        // Directed cases
        run_instr(E_ADD,  0, 0, 2, -1);
        run_instr(E_LW,   0, 2, 2, -1);
        run_instr(E_BEQ,  0, 0, 1, -1);
        run_instr(E_BNE,  0, 0, 1, -1);
        run_instr(E_BEQ,  0, 0, 0, -1);
        run_instr(E_BNE,  0, 0, 0, -1);
        run_instr(E_JAL,  0, 0, 2, -1);
        run_instr(E_ILL,  0, 0, 2, -1);
        run_instr(27,     0, 0, 2, -1);
        run_instr(E_JALR, 1, 0, 2, -1);
        run_instr(E_SW,   2, 1, 2, -1);

        // Reset while an add sits in EX: abandoned, counter cleared
        run_instr(E_ADD, 0, 0, 2, 3);
        do_reset(2);

        // 17 jumps: 4-bit counter wraps to 1
        repeat (17) run_instr(E_J, 0, 0, 2, -1);
        vectors++;
        assert (ir4 === 4'd1) else begin
            miscompares++;
            $error("FAIL wrap4 observed=%0d expected=1", ir4);
        end

        // Random instruction mix with random stalls
        repeat (120) begin
            run_instr($urandom_range(0, N_ENT - 1), $urandom_range(0, 2),
                      $urandom_range(0, 2), 2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
